// File: rtl/bootram_pkg.sv
// Shared types and constants for the boot RAM bus controller.
// Lane i of a 32-bit word is always bits [8i+7:8i].
package bootram_pkg;

  localparam int unsigned LANES           = 4;
  localparam int unsigned ADDR_W_DEFAULT  = 11;
  localparam int unsigned READ_LAT_BYPASS = 1;
  localparam int unsigned READ_LAT_PIPE   = 2;

  typedef enum logic [2:0] {
    StIdle,
    StCpuWr,
    StLdWr,
    StRdWait,
    StRdCap,
    StDone
  } state_e;

  function automatic logic [7:0] lane_slice(input logic [31:0] word, input int unsigned lane);
    return word[8*lane +: 8];
  endfunction

endpackage

// File: rtl/bootram_bus_ctrl.sv
// Converts PicoRV32 native memory requests and UART loader byte writes into
// strobes for four byte-lane boot RAMs; every output is registered.
module bootram_bus_ctrl
  import bootram_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEFAULT,
  parameter int unsigned READ_LAT = READ_LAT_BYPASS,
  parameter bit          WP_EN    = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_sel,
  input  logic              i_mem_valid,
  output logic              o_mem_ready,
  input  logic [31:0]       i_mem_addr,
  input  logic [31:0]       i_mem_wdata,
  input  logic [3:0]        i_mem_wstrb,
  output logic [31:0]       o_mem_rdata,
  input  logic              i_wp_lock,
  input  logic              i_ld_valid,
  output logic              o_ld_ready,
  input  logic [ADDR_W+1:0] i_ld_addr,
  input  logic [7:0]        i_ld_data,
  output logic [3:0]        o_ram_ce,
  output logic [3:0]        o_ram_wre,
  output logic              o_ram_oce,
  output logic [ADDR_W-1:0] o_ram_ad,
  output logic [31:0]       o_ram_din,
  input  logic [31:0]       i_ram_dout
);

  state_e            r_state;
  logic [1:0]        r_wait;
  logic              r_mem_ready;
  logic              r_ld_ready;
  logic [31:0]       r_mem_rdata;
  logic [3:0]        r_ram_ce;
  logic [3:0]        r_ram_wre;
  logic              r_ram_oce;
  logic [ADDR_W-1:0] r_ram_ad;
  logic [31:0]       r_ram_din;

  logic [3:0]        w_ld_lane;
  logic              w_wp_block;
  logic              w_unused_addr;

  assign w_ld_lane     = 4'b0001 << i_ld_addr[1:0];
  assign w_wp_block    = WP_EN && i_wp_lock;
  assign w_unused_addr = ^{i_mem_addr[31:ADDR_W+2], i_mem_addr[1:0]};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_wait      <= '0;
      r_mem_ready <= 1'b0;
      r_ld_ready  <= 1'b0;
      r_mem_rdata <= '0;
      r_ram_ce    <= '0;
      r_ram_wre   <= '0;
      r_ram_oce   <= 1'b0;
      r_ram_ad    <= '0;
      r_ram_din   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          // Loader wins a same-cycle tie so a boot load is never interleaved.
          if (i_ld_valid) begin
            r_state   <= StLdWr;
            r_ram_ad  <= i_ld_addr[ADDR_W+1:2];
            r_ram_ce  <= w_ld_lane;
            r_ram_wre <= w_ld_lane;
            r_ram_din <= {LANES{i_ld_data}};
          end else if (i_sel && i_mem_valid) begin
            r_ram_ad  <= i_mem_addr[ADDR_W+1:2];
            r_ram_din <= i_mem_wdata;
            if (i_mem_wstrb != 4'h0) begin
              r_state   <= StCpuWr;
              r_ram_ce  <= w_wp_block ? 4'h0 : i_mem_wstrb;
              r_ram_wre <= w_wp_block ? 4'h0 : i_mem_wstrb;
            end else begin
              r_state   <= StRdWait;
              r_ram_ce  <= 4'hF;
              r_ram_wre <= 4'h0;
              r_wait    <= 2'(READ_LAT - 1);
            end
          end
        end

        // The ready register doubles as the phase bit: strobe cycle, then ready cycle.
        StCpuWr: begin
          r_ram_ce  <= 4'h0;
          r_ram_wre <= 4'h0;
          if (!r_mem_ready) begin
            r_mem_ready <= 1'b1;
          end else begin
            r_mem_ready <= 1'b0;
            r_state     <= StDone;
          end
        end

        StLdWr: begin
          r_ram_ce  <= 4'h0;
          r_ram_wre <= 4'h0;
          if (!r_ld_ready) begin
            r_ld_ready <= 1'b1;
          end else begin
            r_ld_ready <= 1'b0;
            r_state    <= StDone;
          end
        end

        StRdWait: begin
          r_ram_ce  <= 4'h0;
          r_ram_wre <= 4'h0;
          if (r_wait == 2'd0) begin
            r_ram_oce <= 1'b0;
            r_state   <= StRdCap;
          end else begin
            r_wait    <= r_wait - 2'd1;
            r_ram_oce <= (READ_LAT == READ_LAT_PIPE) && (r_wait == 2'd1);
          end
        end

        StRdCap: begin
          if (!r_mem_ready) begin
            r_mem_rdata <= i_ram_dout;
            r_mem_ready <= 1'b1;
          end else begin
            r_mem_ready <= 1'b0;
            r_state     <= StDone;
          end
        end

        // One dead cycle so a valid still high after ready is not taken twice.
        StDone: begin
          r_state <= StIdle;
        end

        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_mem_ready = r_mem_ready;
  assign o_ld_ready  = r_ld_ready;
  assign o_mem_rdata = r_mem_rdata;
  assign o_ram_ce    = r_ram_ce;
  assign o_ram_wre   = r_ram_wre;
  assign o_ram_oce   = r_ram_oce;
  assign o_ram_ad    = r_ram_ad;
  assign o_ram_din   = r_ram_din;

endmodule

// File: tb/tb_bootram_bus_ctrl.sv
// Bench for bootram_bus_ctrl: a bypass/write-protect instance and a pipelined instance,
// each with behavioural byte-lane RAMs and a word-level reference memory.
module tb_bootram_bus_ctrl;
  import bootram_pkg::*;

  logic        clk;
  logic        reset;
  logic        sel;
  logic [1:0]  mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        wp_lock;
  logic [1:0]  ld_valid;
  logic [12:0] ld_addr;
  logic [7:0]  ld_data;

  logic        mem_ready [2];
  logic [31:0] mem_rdata [2];
  logic        ld_ready  [2];
  logic [3:0]  ram_ce    [2];
  logic [3:0]  ram_wre   [2];
  logic        ram_oce   [2];
  logic [10:0] ram_ad    [2];
  logic [31:0] ram_din   [2];
  logic [31:0] ram_dout  [2];

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] model [2][2048];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bootram_bus_ctrl #(.ADDR_W(11), .READ_LAT(1), .WP_EN(1'b1)) u_dut_byp (
    .i_clk(clk), .i_reset(reset), .i_sel(sel), .i_mem_valid(mem_valid[0]),
    .o_mem_ready(mem_ready[0]), .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata),
    .i_mem_wstrb(mem_wstrb), .o_mem_rdata(mem_rdata[0]), .i_wp_lock(wp_lock),
    .i_ld_valid(ld_valid[0]), .o_ld_ready(ld_ready[0]), .i_ld_addr(ld_addr),
    .i_ld_data(ld_data), .o_ram_ce(ram_ce[0]), .o_ram_wre(ram_wre[0]),
    .o_ram_oce(ram_oce[0]), .o_ram_ad(ram_ad[0]), .o_ram_din(ram_din[0]),
    .i_ram_dout(ram_dout[0])
  );

  bootram_bus_ctrl #(.ADDR_W(11), .READ_LAT(2), .WP_EN(1'b0)) u_dut_pipe (
    .i_clk(clk), .i_reset(reset), .i_sel(sel), .i_mem_valid(mem_valid[1]),
    .o_mem_ready(mem_ready[1]), .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata),
    .i_mem_wstrb(mem_wstrb), .o_mem_rdata(mem_rdata[1]), .i_wp_lock(wp_lock),
    .i_ld_valid(ld_valid[1]), .o_ld_ready(ld_ready[1]), .i_ld_addr(ld_addr),
    .i_ld_data(ld_data), .o_ram_ce(ram_ce[1]), .o_ram_wre(ram_wre[1]),
    .o_ram_oce(ram_oce[1]), .o_ram_ad(ram_ad[1]), .o_ram_din(ram_din[1]),
    .i_ram_dout(ram_dout[1])
  );

  // Behavioural lane RAMs: index 0 registered read only, index 1 adds an oce-gated output reg.
  logic [7:0]  lram  [2][4][2048];
  logic [31:0] stage [2];
  logic [31:0] oreg;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int l = 0; l < 4; l++) begin
        if (ram_ce[d][l]) begin
          if (ram_wre[d][l]) lram[d][l][ram_ad[d]] <= lane_slice(ram_din[d], l);
          else stage[d][8*l +: 8] <= lram[d][l][ram_ad[d]];
        end
      end
    end
    if (ram_oce[1]) oreg <= stage[1];
  end

  assign ram_dout[0] = stage[0];
  assign ram_dout[1] = oreg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic bit wp_en(input int d);
    return d == 0;
  endfunction

  function automatic int unsigned lat_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  task automatic chk_all_zero(input int d);
    chk("rst_ce", 32'(ram_ce[d]), 0);
    chk("rst_wre", 32'(ram_wre[d]), 0);
    chk("rst_oce", 32'(ram_oce[d]), 0);
    chk("rst_ad", 32'(ram_ad[d]), 0);
    chk("rst_din", ram_din[d], 0);
    chk("rst_rdata", mem_rdata[d], 0);
    chk("rst_mem_ready", 32'(mem_ready[d]), 0);
    chk("rst_ld_ready", 32'(ld_ready[d]), 0);
  endtask

  task automatic cpu_write(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input logic lock);
    logic [3:0] exp_strb;
    exp_strb = (wp_en(d) && lock) ? 4'h0 : wstrb;
    @(posedge clk); #1;
    sel = 1'b1; mem_valid[d] = 1'b1; mem_addr = addr; mem_wdata = wdata;
    mem_wstrb = wstrb; wp_lock = lock;
    @(negedge clk);
    chk("wr_t0_ce", 32'(ram_ce[d]), 0);
    @(negedge clk);
    chk("wr_ad", 32'(ram_ad[d]), 32'(addr[12:2]));
    chk("wr_ce", 32'(ram_ce[d]), 32'(exp_strb));
    chk("wr_wre", 32'(ram_wre[d]), 32'(exp_strb));
    chk("wr_din", ram_din[d], wdata);
    chk("wr_ready_t1", 32'(mem_ready[d]), 0);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      chk("wr_ready", 32'(mem_ready[d]), 32'(k == 2));
      chk("wr_ce_off", 32'(ram_ce[d]), 0);
      chk("wr_ld_ready", 32'(ld_ready[d]), 0);
      if (k == 3) begin
        mem_valid[d] = 1'b0; sel = 1'b0;
      end
    end
    for (int l = 0; l < 4; l++)
      if (exp_strb[l]) model[d][addr[12:2]][8*l +: 8] = wdata[8*l +: 8];
  endtask

  task automatic cpu_read(input int d, input logic [31:0] addr);
    int unsigned lat;
    logic [31:0] exp;
    lat = lat_of(d);
    exp = model[d][addr[12:2]];
    @(posedge clk); #1;
    sel = 1'b1; mem_valid[d] = 1'b1; mem_addr = addr; mem_wstrb = 4'h0;
    @(negedge clk);
    chk("rd_t0_ce", 32'(ram_ce[d]), 0);
    @(negedge clk);
    chk("rd_ad", 32'(ram_ad[d]), 32'(addr[12:2]));
    chk("rd_ce", 32'(ram_ce[d]), 32'hF);
    chk("rd_wre", 32'(ram_wre[d]), 0);
    chk("rd_ready_t1", 32'(mem_ready[d]), 0);
    for (int k = 2; k <= int'(lat) + 4; k++) begin
      @(negedge clk);
      chk("rd_ready", 32'(mem_ready[d]), 32'(k == int'(lat) + 2));
      chk("rd_oce", 32'(ram_oce[d]), 32'(lat == 2 && k == 2));
      chk("rd_ce_off", 32'(ram_ce[d]), 0);
      if (k >= int'(lat) + 2) chk("rd_data", mem_rdata[d], exp);
      if (k == int'(lat) + 3) begin
        mem_valid[d] = 1'b0; sel = 1'b0;
      end
    end
  endtask

  task automatic ld_write(input int d, input logic [12:0] addr, input logic [7:0] data,
                          input logic lock, input bit with_cpu_rd, input logic [31:0] rd_addr);
    logic [3:0] lane;
    lane = 4'b0001 << addr[1:0];
    @(posedge clk); #1;
    ld_valid[d] = 1'b1; ld_addr = addr; ld_data = data; wp_lock = lock;
    if (with_cpu_rd) begin
      sel = 1'b1; mem_valid[d] = 1'b1; mem_addr = rd_addr; mem_wstrb = 4'h0;
    end
    @(negedge clk);
    @(negedge clk);
    chk("ld_ad", 32'(ram_ad[d]), 32'(addr[12:2]));
    chk("ld_ce", 32'(ram_ce[d]), 32'(lane));
    chk("ld_wre", 32'(ram_wre[d]), 32'(lane));
    chk("ld_din", ram_din[d], {4{data}});
    for (int k = 2; k <= 3; k++) begin
      @(negedge clk);
      chk("ld_ready", 32'(ld_ready[d]), 32'(k == 2));
      chk("ld_mem_ready", 32'(mem_ready[d]), 0);
      chk("ld_ce_off", 32'(ram_ce[d]), 0);
    end
    ld_valid[d] = 1'b0;
    model[d][addr[12:2]][8*addr[1:0] +: 8] = data;
    if (with_cpu_rd) cpu_read(d, rd_addr);
  endtask

  function automatic logic [31:0] rand_addr(input int unsigned word);
    logic [31:0] r;
    r = $urandom();
    return {r[31:13], 7'd0, word[3:0], r[1:0]};
  endfunction

  initial begin
    reset = 1'b1; sel = 1'b0; mem_valid = '0; mem_addr = '0; mem_wdata = '0;
    mem_wstrb = '0; wp_lock = 1'b0; ld_valid = '0; ld_addr = '0; ld_data = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) chk_all_zero(d);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk_all_zero(d);

    // Preload a 16-word pool in both instances
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 16; w++) cpu_write(d, rand_addr(w), $urandom(), 4'hF, 1'b0);

    // Directed: full write, bypass and pipelined reads
    for (int d = 0; d < 2; d++) begin
      cpu_write(d, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0);
      cpu_read(d, 32'h0000_0010);
    end

    // Directed: single-byte write on lane 2
    for (int d = 0; d < 2; d++) begin
      cpu_write(d, 32'h0000_0020, 32'h00AB_0000, 4'b0100, 1'b0);
      cpu_read(d, 32'h0000_0020);
    end

    // Directed: loader beats a same-cycle CPU read
    for (int d = 0; d < 2; d++) ld_write(d, 13'h0007, 8'h5A, 1'b0, 1'b1, 32'h0000_0004);

    // Directed: write protect on instance 0, ignored on instance 1
    for (int d = 0; d < 2; d++) begin
      cpu_write(d, 32'h0000_0010, 32'h1234_5678, 4'hF, 1'b1);
      cpu_read(d, 32'h0000_0010);
      ld_write(d, 13'h0011, 8'h77, 1'b1, 1'b0, 32'h0);
      cpu_read(d, 32'h0000_0010);
    end
    wp_lock = 1'b0;

    // Directed: requests with sel=0 are ignored
    @(posedge clk); #1;
    sel = 1'b0; mem_valid = 2'b11; mem_wstrb = 4'hF; mem_addr = 32'h0000_0008;
    repeat (4) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("nosel_ce", 32'(ram_ce[d]), 0);
        chk("nosel_ready", 32'(mem_ready[d]), 0);
      end
    end
    mem_valid = 2'b00;

    // Directed: reset in the middle of a pipelined read, then re-issue
    @(posedge clk); #1;
    sel = 1'b1; mem_valid[1] = 1'b1; mem_addr = 32'h0000_0014; mem_wstrb = 4'h0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1; #1;
    chk_all_zero(1);
    mem_valid[1] = 1'b0; sel = 1'b0;
    @(posedge clk); #1; reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_ready", 32'(mem_ready[1]), 0);
      chk("post_rst_ce", 32'(ram_ce[1]), 0);
    end
    cpu_read(1, 32'h0000_0014);

    // Randomised mix checked against the word-level model
    for (int i = 0; i < 60; i++) begin
      int unsigned d, op, w;
      logic [31:0] a;
      logic [12:0] la;
      d  = $urandom_range(0, 1);
      op = $urandom_range(0, 2);
      w  = $urandom_range(0, 15);
      a  = rand_addr(w);
      la = a[12:0];
      case (op)
        0: cpu_write(int'(d), a, $urandom(), 4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
        1: cpu_read(int'(d), a);
        default: ld_write(int'(d), la, 8'($urandom()), 1'($urandom_range(0, 1)), 1'b0, 32'h0);
      endcase
    end
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 16; w++) cpu_read(d, rand_addr(w));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bootram_bus_ctrl.md
Name: bootram_bus_ctrl

Overview:
Bus-side controller that sits directly upstream of the four 2Kx8 single-port boot RAM byte lanes (lane 0..3) in picotiny. It converts the PicoRV32 native memory handshake (valid/ready, wstrb) into per-lane ce/wre/oce/ad/din strobes and returns the assembled 32-bit read word. A secondary byte-wide loader port lets the UART boot loader write boot RAM.

Parameters:
ADDR_W, 11, word address width per lane (2048 words)
READ_LAT, 1, RAM read latency in clocks: 1 = bypass lanes, 2 = pipeline lanes
WP_EN, 0, 1 enables the CPU write-protect input wp_lock

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
sel  input  1  address decode hit for the boot RAM region
mem_valid  input  1  CPU request valid
mem_ready  output  1  one-cycle completion pulse
mem_addr  input  32  byte address; [ADDR_W+1:2] used
mem_wdata  input  32  write data
mem_wstrb  input  4  byte enables; 0 = read
mem_rdata  output  32  read data, valid while mem_ready=1
wp_lock  input  1  blocks CPU writes when WP_EN=1
ld_valid  input  1  loader byte-write request
ld_ready  output  1  one-cycle loader completion pulse
ld_addr  input  ADDR_W+2  loader byte address
ld_data  input  8  loader byte
ram_ce  output  4  per-lane clock enable
ram_wre  output  4  per-lane write enable
ram_oce  output  1  output-register enable, common to all lanes
ram_ad  output  ADDR_W  word address, common to all lanes
ram_din  output  32  lane i data = bits [8i+7:8i]
ram_dout  input  32  lane i read data = bits [8i+7:8i]

Behaviour:
- Reset (async, active-high): state IDLE; every output 0, including mem_rdata. Any in-flight request is dropped; the requester must re-issue it.
- All outputs are registered.
- FSM states: IDLE, CPU_WR, LD_WR, RD_WAIT, RD_CAP, DONE.
- IDLE, accept cycle T:
  - ld_valid=1 has priority over a CPU request (sel&mem_valid) seen in the same cycle.
  - The loader goes to LD_WR. The CPU goes to CPU_WR if mem_wstrb!=0, otherwise to RD_WAIT.
- Cycle T+1 (strobe cycle):
  - ram_ad is taken from mem_addr[ADDR_W+1:2] for CPU requests and from ld_addr[ADDR_W+1:2] for loader requests.
  - CPU write: ram_ce=ram_wre=mem_wstrb; ram_din=mem_wdata.
  - Loader write: one-hot ce/wre on lane ld_addr[1:0]; ld_data is replicated into all four din bytes.
  - Read: ram_ce=4'hF, ram_wre=0.
  - In every case ram_ce/ram_wre return to 0 at T+2.
- Write protect: WP_EN=1 and wp_lock=1 during a CPU write means ram_ce=ram_wre=0 throughout, but the write still completes normally. Loader writes ignore wp_lock.
- Write completion: mem_ready (CPU) or ld_ready (loader) is high for exactly one cycle, at T+2. The FSM then passes through DONE at T+3 and returns to IDLE at T+4.
- Read timing:
  - RD_WAIT holds for READ_LAT-1 cycles after T+1.
  - ram_oce is high for one cycle at T+1+READ_LAT-1 when READ_LAT=2. It is held 0 otherwise.
  - RD_CAP captures ram_dout into mem_rdata at the end of cycle T+1+READ_LAT.
  - mem_ready pulses at T+2+READ_LAT, then DONE, then IDLE.
  - mem_rdata holds its value until the next read capture.
- DONE exists so a mem_valid still high in the cycle after ready is never re-accepted. Requests arriving during DONE wait for IDLE.
- Requests with sel=0 are ignored entirely.
- Inputs are sampled only in the accept cycle; the requester must hold them stable until its ready pulse.
- The loader can starve the CPU while ld_valid stays continuously high. This is intended during boot load.

Decomposition:
- Package bootram_pkg holds:
  - the state enum
  - LANES=4
  - the default ADDR_W
  - the READ_LAT_BYPASS=1 and READ_LAT_PIPE=2 constants
  - the lane slice helper (bits [8i+7:8i])
- No sub-module. The four lane RAMs are instantiated by the parent next to this controller.

Test Plan:
1. Write: CPU writes 0xDEADBEEF, wstrb=4'hF, addr 0x0000_0010 -> at T+1 ram_ad=4, ram_ce=ram_wre=4'hF, ram_din=0xDEADBEEF; mem_ready pulse at T+2 only.
2. Read, bypass: read of addr 0x10 with READ_LAT=1, behavioural lanes preloaded -> mem_rdata=0xDEADBEEF with mem_ready at T+3. Repeat with READ_LAT=2 -> ram_oce pulse at T+2, mem_ready at T+4.
3. Byte write: wstrb=4'b0100, wdata=0x00AB0000, addr 0x20 -> only lane 2 written (ram_ce=ram_wre=4'b0100); readback gives 0xXXABXXXX with the other bytes unchanged.
4. Loader priority: ld_valid with ld_addr=13'h0007, ld_data=0x5A, and a CPU read in the same cycle -> lane 3 written at ad=1 first, ld_ready at T+2; the CPU read is accepted at T+4 and returns 0x5Axxxxxx.
5. Write protect: WP_EN=1, wp_lock=1, CPU write 0x12345678 -> ram_wre stays 0 and mem_ready still pulses; readback returns the old value. A loader write under the same lock succeeds.
6. Reset mid-read: assert reset at T+2 of a READ_LAT=2 read -> all outputs 0 immediately, no mem_ready; after release, a re-issued read completes normally.
